// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost flags and error pulses.
// Define FIFO_FWFT_EN for first-word-fall-through read_data; default is registered read.
module sync_fifo_param #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 256,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write_req,
    input  logic [DATA_W-1:0] write_data,
    input  logic              read_req,
    output logic [DATA_W-1:0] read_data,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0] AF_C    = (ADDR_W + 1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_C    = (ADDR_W + 1)'(AE_LEVEL);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic [ADDR_W-1:0] wr_idx;
    logic [ADDR_W-1:0] rd_idx;
    logic              wr_ok;
    logic              rd_ok;

    assign wr_idx = wr_ptr[ADDR_W-1:0];
    assign rd_idx = rd_ptr[ADDR_W-1:0];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_idx == rd_idx) && (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);

    // Pointer difference is the occupancy; the extra MSB covers the full case.
    assign count        = wr_ptr - rd_ptr;
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    // A simultaneous read frees the slot, so a write into a full FIFO still lands.
    assign rd_ok = read_req & ~empty;
    assign wr_ok = write_req & (~full | rd_ok);

    always_ff @(posedge clk) begin
        if (reset && wr_ok) begin
            mem[wr_idx] <= write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_ok) rd_ptr <= rd_ptr + PTR_ONE;
            overflow  <= write_req & ~wr_ok;
            underflow <= read_req & ~rd_ok;
        end
    end

`ifdef FIFO_FWFT_EN
    assign read_data = empty ? '0 : mem[rd_idx];
`else
    logic [DATA_W-1:0] read_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            read_q <= '0;
        end else if (rd_ok) begin
            read_q <= mem[rd_idx];
        end
    end

    assign read_data = read_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param at DEPTH=16.
// Honours FIFO_FWFT_EN for read_data timing expectations.
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       reset;
    logic       write_req;
    logic [7:0] write_data;
    logic       read_req;
    logic [7:0] read_data;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    int n_asserts = 0;
    int n_fail    = 0;

    sync_fifo_param #(.DATA_W(8), .DEPTH(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .write_req    (write_req),
        .write_data   (write_data),
        .read_req     (read_req),
        .read_data    (read_data),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_asserts++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic w, input logic [7:0] d, input logic r);
        write_req  = w;
        write_data = d;
        read_req   = r;
        @(posedge clk);
        #1;
        write_req = 1'b0;
        read_req  = 1'b0;
    endtask

    // Pops one word and checks it under either read timing.
    task automatic pop_check(input string tag, input logic [7:0] exp);
`ifdef FIFO_FWFT_EN
        check(tag, read_data, exp);
        cyc(1'b0, 8'h00, 1'b1);
`else
        cyc(1'b0, 8'h00, 1'b1);
        check(tag, read_data, exp);
`endif
    endtask

    logic [7:0] q[$];

    initial begin
        logic       w;
        logic       r;
        logic [7:0] d;
        logic       rok;
        logic       wok;
        logic [7:0] popped;

        reset      = 1'b0;
        write_req  = 1'b0;
        write_data = 8'h00;
        read_req   = 1'b0;

        // reset with a pending write
        cyc(1'b1, 8'h77, 1'b0);
        cyc(1'b1, 8'h77, 1'b0);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_af", almost_full, 0);
        check("rst_ae", almost_empty, 1);
        check("rst_ovf", overflow, 0);
        check("rst_unf", underflow, 0);
`ifndef FIFO_FWFT_EN
        check("rst_rdata", read_data, 0);
`endif
        reset = 1'b1;
        cyc(1'b0, 8'h00, 1'b0);
        check("rst_nowrite", empty, 1);

        // fill
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 8'(i), 1'b0);
            check("fill_count", count, i + 1);
            check("fill_af", almost_full, (i + 1) >= 12);
            check("fill_ae", almost_empty, (i + 1) <= 4);
            check("fill_full", full, (i + 1) == 16);
            check("fill_empty", empty, 0);
        end
        cyc(1'b1, 8'hEE, 1'b0);
        check("ovf_pulse", overflow, 1);
        check("ovf_count", count, 16);
        cyc(1'b0, 8'h00, 1'b0);
        check("ovf_clear", overflow, 0);
        check("ovf_count2", count, 16);

        // drain
        for (int i = 0; i < 16; i++) begin
            pop_check("drain_data", 8'(i));
            check("drain_count", count, 15 - i);
            check("drain_unf", underflow, 0);
        end
        check("drain_empty", empty, 1);
        cyc(1'b0, 8'h00, 1'b1);
        check("unf_pulse", underflow, 1);
        check("unf_count", count, 0);
`ifndef FIFO_FWFT_EN
        check("unf_hold", read_data, 8'h0F);
`endif
        cyc(1'b0, 8'h00, 1'b0);
        check("unf_clear", underflow, 0);
`ifndef FIFO_FWFT_EN
        check("unf_hold2", read_data, 8'h0F);
`endif

        // full + simultaneous write/read
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0);
        check("f2_full", full, 1);
`ifdef FIFO_FWFT_EN
        check("fwr_head", read_data, 8'h10);
        cyc(1'b1, 8'hAA, 1'b1);
`else
        cyc(1'b1, 8'hAA, 1'b1);
        check("fwr_head", read_data, 8'h10);
`endif
        check("fwr_count", count, 16);
        check("fwr_ovf", overflow, 0);
        check("fwr_full", full, 1);
        for (int i = 1; i < 16; i++) pop_check("fwr_drain", 8'(8'h10 + i));
        pop_check("fwr_last", 8'hAA);
        check("fwr_empty", empty, 1);

        // empty + simultaneous write/read
        cyc(1'b1, 8'h55, 1'b1);
        check("ewr_unf", underflow, 1);
        check("ewr_count", count, 1);
`ifndef FIFO_FWFT_EN
        check("ewr_hold", read_data, 8'hAA);
`endif
        pop_check("ewr_data", 8'h55);
        check("ewr_count2", count, 0);

        // random mix against a queue model
        for (int k = 0; k < 40; k++) begin
            w = ($urandom_range(0, 9) < 6);
            r = ($urandom_range(0, 9) < 5);
            d = 8'($urandom);
            rok = r && (q.size() > 0);
            wok = w && ((q.size() < 16) || rok);
`ifdef FIFO_FWFT_EN
            if (q.size() > 0) check("rnd_head", read_data, q[0]);
`endif
            cyc(w, d, r);
            popped = 8'h00;
            if (rok) popped = q.pop_front();
            if (wok) q.push_back(d);
`ifndef FIFO_FWFT_EN
            if (rok) check("rnd_data", read_data, popped);
`endif
            check("rnd_count", count, q.size());
            check("rnd_ovf", overflow, w && !wok);
            check("rnd_unf", underflow, r && !rok);
        end

        // reset mid-stream
        cyc(1'b1, 8'hC1, 1'b0);
        cyc(1'b1, 8'hC2, 1'b0);
        reset = 1'b0;
        cyc(1'b1, 8'hC3, 1'b1);
        reset = 1'b1;
        check("mrst_empty", empty, 1);
        check("mrst_count", count, 0);
        cyc(1'b0, 8'h00, 1'b1);
        check("mrst_unf", underflow, 1);
        cyc(1'b1, 8'h99, 1'b0);
        pop_check("mrst_new", 8'h99);
        check("mrst_empty2", empty, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asserts, n_fail);
        $finish;
    end

endmodule
